pipe_cla_adder: RTL and testbench
=================================

# pipe_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshakes on both sides. Width, lookahead group size and pipeline depth are set by parameters. The carry chain is cut into `STAGES` register-separated slices, and each slice is built from grouped lookahead cells. It serves as the shared datapath adder for ALU, address and accumulator paths that need more than 16 bits or a clock rate a flat lookahead tree cannot meet.

## Interface
- `WIDTH`, 32: operand/result width in bits.
- `GROUP`, 4: bits per lookahead group cell.
- `STAGES`, 2: pipeline stages, which equals the latency in cycles. Legal range is 1..WIDTH/GROUP.
- `clk` input 1: the single clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: the operand beat is valid.
- `in_ready` output 1: the block accepts a beat this cycle.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `cin` input 1: carry-in. Set it to 1 for plain subtract and 0 for subtract-with-borrow.
- `sub` input 1: 0 computes a+b+cin; 1 computes a+~b+cin.
- `out_valid` output 1: a result is valid.
- `out_ready` input 1: the consumer accepts the result.
- `sum` output WIDTH: result.
- `cout` output 1: carry out of the MSB. In subtract mode, 0 means borrow.
- `ovf` output 1: signed overflow, i.e. carry into the MSB XOR `cout`.
- `zero` output 1: `sum` is all zeros.

## Operation
- Slice width is SW = WIDTH/STAGES. SW must be a multiple of GROUP, and WIDTH/GROUP ≥ STAGES. Any violation is an elaboration error (`$error` in a generate check).
- Stage k (k = 0..STAGES-1) adds bits [k·SW +: SW] using the registered carry from stage k-1. Stage 0 uses the effective cin.
- Bits of higher slices travel alongside in pipeline registers until their stage. Bits already computed are carried forward.
- Within a slice: g = a&b', p = a^b', where b' = sub ? ~b : b. Group cells produce group G/P, and a second lookahead level produces the carries into each group.
- The ovf term uses the carry into bit WIDTH-1, taken from the final stage.
- Each stage has a valid bit v[k]. Stage k advances when it is empty or stage k+1 advances. The output stage advances when `out_ready` is high.
- `in_ready` = !v[0] | advance[1]. It depends combinationally on `out_ready` through the chain; there is no skid buffer.
- Results leave in acceptance order. There is no reordering and no drop.

## Timing
- Latency: a beat accepted on cycle t appears with `out_valid` on cycle t+STAGES if no stall occurs.
- Throughput: one beat per cycle while `out_ready` is high.
- Capacity: STAGES beats in flight. When all v[k] are 1 and `out_ready` is 0, `in_ready` is 0.
- Output stability: while `out_valid` is 1 and `out_ready` is 0, `sum`, `cout`, `ovf` and `zero` hold stable.
- Simultaneous events: with the pipe full, `out_ready` = 1 and `in_valid` = 1, a new beat is accepted in the same cycle the head leaves.
- Reset values: `rst_n` low clears every v[k] and every data register immediately. `out_valid`, `sum`, `cout`, `ovf` and `zero` are 0, and `in_ready` is 1 after release.
- Reset mid-operation: beats in flight are discarded, and no result from before reset ever appears.
- Wrap-around: unsigned overflow wraps modulo 2^WIDTH and is flagged only via `cout`/`ovf`.

## Structure
- Shared package `adder_pkg` holds:
  - the default parameter constants `ADD_WIDTH`, `ADD_GROUP`, `ADD_STAGES`;
  - the `add_flags_t` struct {cout, ovf, zero}.
- Sub-module `cla_group`:
  - parametrised by GROUP;
  - inputs g/p vectors and a carry-in;
  - outputs the per-bit carries plus group G/P;
  - instanced WIDTH/GROUP times under generate.
- The second-level lookahead and the pipeline registers live in `pipe_cla_adder`.

## Test plan
All scenarios use WIDTH=32, GROUP=4, STAGES=2.
- a=0xFFFF_FFFF, b=1, cin=0, sub=0 → two cycles later: sum=0, cout=1, zero=1, ovf=0.
- a=0x7FFF_FFFF, b=1, sub=0 → sum=0x8000_0000, ovf=1, cout=0. Then a=5, b=7, sub=1, cin=1 → sum=0xFFFF_FFFE, cout=0, ovf=0.
- Slice-boundary carry: a=0x0000_FFFF, b=1 → sum=0x0001_0000, which proves the carry crosses from stage 0 to stage 1.
- Backpressure: send 5 back-to-back beats with `out_ready` low for cycles 2–6 → `in_ready` drops after 2 beats are held. All 5 results later emerge in order, and outputs hold stable while stalled.
- Reset mid-operation: drop `rst_n` with 2 beats in flight → `out_valid`=0 immediately. After release, nothing is emitted until a new beat arrives.
- Random: 10k beats with random `out_ready` toggling → every result matches a behavioural {a+(sub?~b:b)+cin} model and its flags, in order, with no loss.

Source files
------------

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared defaults and result flag type for the pipelined lookahead adder
package adder_pkg;

  localparam int ADD_WIDTH  = 32;
  localparam int ADD_GROUP  = 4;
  localparam int ADD_STAGES = 2;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } add_flags_t;

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - one lookahead group cell: per-bit carries plus group generate/propagate
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] g,
  input  logic [GROUP-1:0] p,
  input  logic             ci,
  output logic [GROUP-1:0] c,
  output logic             gg,
  output logic             gp
);

  // Carry into bit n as a flat sum of products over bits below n, seeded by c0.
  function automatic logic carry_into(input logic [GROUP-1:0] gv, input logic [GROUP-1:0] pv,
                                      input int n, input logic c0);
    logic acc;
    logic prop;
    acc  = 1'b0;
    prop = 1'b1;
    for (int m = GROUP - 1; m >= 0; m--) begin
      if (m < n) begin
        acc  = acc | (prop & gv[m]);
        prop = prop & pv[m];
      end
    end
    return acc | (prop & c0);
  endfunction

  always_comb begin
    c = '0;
    for (int i = 0; i < GROUP; i++) begin
      c[i] = carry_into(g, p, i, ci);
    end
    gg = carry_into(g, p, GROUP, 1'b0);
    gp = &p;
  end

endmodule

// File: rtl/pipe_cla_adder.sv
// rtl/pipe_cla_adder.sv - pipelined carry-lookahead adder/subtractor with valid/ready on both sides
// Each stage resolves one slice; pending slices travel as propagate/generate bits beside it.
module pipe_cla_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADD_WIDTH,
  parameter int GROUP  = ADD_GROUP,
  parameter int STAGES = ADD_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW  = WIDTH / ((STAGES < 1) ? 1 : STAGES);
  localparam int NG  = SW / GROUP;
  localparam int NGT = WIDTH / GROUP;
  localparam int RS  = (STAGES > 1) ? STAGES - 1 : 1;

  // Generate bits are only kept for still-pending slices, packed as a shrinking triangle.
  function automatic int goff(input int k);
    return k * WIDTH - (SW * k * (k + 1)) / 2;
  endfunction

  localparam int GBITS = (STAGES > 1) ? goff(STAGES - 1) : 1;

  if ((STAGES < 1) || (WIDTH % STAGES != 0) || (SW % GROUP != 0) || (WIDTH / GROUP < STAGES)) begin : g_bad_params
    $error("pipe_cla_adder: illegal WIDTH/GROUP/STAGES combination");
  end

  function automatic logic la_carry(input logic [NGT-1:0] gv, input logic [NGT-1:0] pv,
                                    input int base, input int n, input logic c0);
    logic acc;
    logic prop;
    acc  = 1'b0;
    prop = 1'b1;
    for (int m = NG - 1; m >= 0; m--) begin
      if (m < n) begin
        acc  = acc | (prop & gv[base+m]);
        prop = prop & pv[base+m];
      end
    end
    return acc | (prop & c0);
  endfunction

  logic [WIDTH-1:0]             bx, gw, pw;
  logic [WIDTH-1:0]             gsel, psel, cbit;
  logic [NGT-1:0]               grp_g, grp_p, grp_c;
  logic [STAGES-1:0]            v, en, cin_s, slice_co;
  logic [STAGES-1:0][WIDTH-1:0] rp;
  logic [RS-1:0]                rc;
  logic [GBITS-1:0]             gpipe;
  add_flags_t                   flags;

  assign bx = sub ? ~b : b;
  assign gw = a & bx;
  assign pw = a ^ bx;

  for (genvar j = 0; j < NGT; j++) begin : g_grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .g  (gsel[j*GROUP +: GROUP]),
      .p  (psel[j*GROUP +: GROUP]),
      .ci (grp_c[j]),
      .c  (cbit[j*GROUP +: GROUP]),
      .gg (grp_g[j]),
      .gp (grp_p[j])
    );
  end

  // Second lookahead level: group carries and slice carry-out from group G/P.
  always_comb begin
    grp_c    = '0;
    slice_co = '0;
    for (int s = 0; s < STAGES; s++) begin
      for (int i = 0; i < NG; i++) begin
        grp_c[s*NG+i] = la_carry(grp_g, grp_p, s * NG, i, cin_s[s]);
      end
      slice_co[s] = la_carry(grp_g, grp_p, s * NG, NG, cin_s[s]);
    end
  end

  always_comb begin
    en = '0;
    en[STAGES-1] = !v[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      en[k] = !v[k] || en[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] pnext;
    logic             vin;
    logic             v_q;
    logic [WIDTH-1:0] p_q;

    if (k == 0) begin : g_head
      assign pin      = pw;
      assign vin      = in_valid;
      assign cin_s[k] = cin;
      assign gsel[SW-1:0] = gw[SW-1:0];
    end else begin : g_body
      assign pin      = rp[k-1];
      assign vin      = v[k-1];
      assign cin_s[k] = rc[k-1];
      assign gsel[k*SW +: SW] = gpipe[goff(k-1) +: SW];
    end

    assign psel[k*SW +: SW] = pin[k*SW +: SW];

    // Resolved bits overwrite their propagate bits in place.
    always_comb begin
      pnext = pin;
      pnext[k*SW +: SW] = pin[k*SW +: SW] ^ cbit[k*SW +: SW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        p_q <= '0;
      end else if (en[k]) begin
        v_q <= vin;
        if (vin) p_q <= pnext;
      end
    end

    assign v[k]  = v_q;
    assign rp[k] = p_q;

    if (k < STAGES - 1) begin : g_carry
      localparam int UW = WIDTH - (k + 1) * SW;
      logic [UW-1:0] gup;
      logic [UW-1:0] g_q;
      logic          c_q;

      if (k == 0) begin : g_src_in
        assign gup = gw[WIDTH-1:SW];
      end else begin : g_src_pipe
        assign gup = gpipe[goff(k-1) + SW +: UW];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          c_q <= 1'b0;
          g_q <= '0;
        end else if (en[k] && vin) begin
          c_q <= slice_co[k];
          g_q <= gup;
        end
      end

      assign rc[k] = c_q;
      assign gpipe[goff(k) +: UW] = g_q;
    end else begin : g_flags
      add_flags_t f_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          f_q <= '0;
        end else if (en[k] && vin) begin
          f_q.cout <= slice_co[k];
          f_q.ovf  <= cbit[WIDTH-1] ^ slice_co[k];
          f_q.zero <= ~|pnext;
        end
      end

      assign flags = f_q;
    end
  end

  assign in_ready  = en[0];
  assign out_valid = v[STAGES-1];
  assign sum       = rp[STAGES-1];
  assign cout      = flags.cout;
  assign ovf       = flags.ovf;
  assign zero      = flags.zero;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// tb/tb_pipe_cla_adder.sv - self-checking bench for pipe_cla_adder against an arithmetic model
module tb_pipe_cla_adder;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [W-1:0] a, b, sum;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_in  = 0;
  int   n_out = 0;
  exp_t q[$];

  logic         have_prev = 1'b0;
  logic [W-1:0] prev_sum;
  logic         prev_cout, prev_ovf, prev_zero;

  pipe_cla_adder #(.WIDTH(32), .GROUP(4), .STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc, input logic ms);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb     = ms ? ~mb : mb;
    full   = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, mc};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
    e.zero = (full[W-1:0] == '0);
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return W'($urandom_range(0, 3));
      default: return W'($urandom);
    endcase
  endfunction

  // Scoreboard: handshakes are sampled on the falling edge, where inputs are settled.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        check("stall_valid", out_valid, 1);
        check("stall_sum", sum, prev_sum);
        check("stall_flags", {cout, ovf, zero}, {prev_cout, prev_ovf, prev_zero});
      end
      if (out_valid && out_ready) begin
        check("out_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("sum", sum, e.sum);
          check("cout", cout, e.cout);
          check("ovf", ovf, e.ovf);
          check("zero", zero, e.zero);
        end
        n_out++;
      end
      have_prev = out_valid && !out_ready;
      prev_sum  = sum;
      prev_cout = cout;
      prev_ovf  = ovf;
      prev_zero = zero;
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin, sub));
        n_in++;
      end
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input logic ts);
    int w;
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("send_accept", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic ts, input logic [W-1:0] es,
                          input logic ec, input logic eo, input logic ez);
    int lat;
    out_ready = 1'b1;
    send(ta, tb_, tc, ts);
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, 2);
    check({name, "_sum"}, sum, es);
    check({name, "_cout"}, cout, ec);
    check({name, "_ovf"}, ovf, eo);
    check({name, "_zero"}, zero, ez);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, cyc, w;
    logic acc;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_flags", {cout, ovf, zero}, 3'b000);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    directed("wrap",     32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 1'b1);
    directed("sovf",     32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000,  1'b0, 1'b1, 1'b0);
    directed("sub_neg",  32'h5,         32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE,  1'b0, 1'b0, 1'b0);
    directed("slice",    32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 32'h0001_0000,  1'b0, 1'b0, 1'b0);
    directed("sub_pos",  32'h7,         32'h5, 1'b1, 1'b1, 32'h2,          1'b1, 1'b0, 1'b0);

    // Backpressure: fill the pipe with the output blocked, then release it.
    out_ready = 1'b0;
    send(32'h10, 32'h1, 1'b0, 1'b0);
    send(32'h20, 32'h2, 1'b0, 1'b0);
    a = 32'h30; b = 32'h3;
    @(negedge clk);
    check("bp_in_ready_full", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_head_sum", sum, 32'h11);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h30, 32'h3, 1'b0, 1'b0);
    send(32'h40, 32'h4, 1'b0, 1'b0);
    send(32'h50, 32'h5, 1'b0, 1'b1);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("bp_drained", q.size(), 0);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(32'h1, 32'h2, 1'b0, 1'b0);
    send(32'h3, 32'h4, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    n_in -= q.size();
    q.delete();
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("midrst_idle", out_valid, 0);
    end
    @(posedge clk);
    #1;

    // Random traffic with random backpressure.
    sent = 0;
    cyc = 0;
    while (sent < 10000 && cyc < 80000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        a = rnd_op(); b = rnd_op(); cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("random_sent", sent, 10000);

    out_ready = 1'b1;
    w = 0;
    while (q.size() > 0 && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain_empty", q.size(), 0);
    check("in_out_count", n_out, n_in);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
